mcycle_issue_ctrl: RTL and testbench

- Initiator side of the MCycle Start/Busy protocol.
- Sits in the EX stage and takes RV32M instructions (MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU) from the pipeline.
- Issues a single-cycle Start with the mapped MCycleOp, stalls the pipeline until Busy drops, then selects, corrects and writes back the result.
- Handles the RISC-V divide-by-zero and signed-overflow cases locally, without engaging the multi-cycle unit.

---
 rtl/mcycle_issue_ctrl_pkg.sv | 40 ++++
 rtl/mcycle_issue_ctrl_fixup.sv | 45 ++++
 rtl/mcycle_issue_ctrl.sv | 136 +++++++++++++
 tb/tb_mcycle_issue_ctrl.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mcycle_issue_ctrl_pkg.sv
// Shared encodings for the MCycle issue controller: RV32M funct3 values,
// MCycleOp codes, FSM states and the default datapath width.
package mcycle_issue_ctrl_pkg;

  localparam int WIDTH = 32;

  localparam logic [2:0] FUNCT3_MUL    = 3'b000;
  localparam logic [2:0] FUNCT3_MULH   = 3'b001;
  localparam logic [2:0] FUNCT3_MULHSU = 3'b010;
  localparam logic [2:0] FUNCT3_MULHU  = 3'b011;
  localparam logic [2:0] FUNCT3_DIV    = 3'b100;
  localparam logic [2:0] FUNCT3_DIVU   = 3'b101;
  localparam logic [2:0] FUNCT3_REM    = 3'b110;
  localparam logic [2:0] FUNCT3_REMU   = 3'b111;

  localparam logic [1:0] MOP_MUL_S = 2'b00;
  localparam logic [1:0] MOP_MUL_U = 2'b01;
  localparam logic [1:0] MOP_DIV_S = 2'b10;
  localparam logic [1:0] MOP_DIV_U = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_WAIT  = 2'b01,
    ST_WB    = 2'b10,
    ST_DRAIN = 2'b11
  } state_t;

  // MULHSU runs on the unsigned multiplier and is corrected afterwards.
  function automatic logic [1:0] map_mop(input logic [2:0] f3);
    logic [1:0] mop;
    unique case (f3)
      FUNCT3_MUL, FUNCT3_MULH:    mop = MOP_MUL_S;
      FUNCT3_MULHSU, FUNCT3_MULHU: mop = MOP_MUL_U;
      FUNCT3_DIV, FUNCT3_REM:     mop = MOP_DIV_S;
      default:                    mop = MOP_DIV_U;
    endcase
    return mop;
  endfunction

endpackage

// File: rtl/mcycle_issue_ctrl_fixup.sv
// Combinational result path: special-case divide detection and value,
// selection of LSW/MSW from the MCycle unit, and MULHSU correction.
module m_result_fixup
  import mcycle_issue_ctrl_pkg::*;
#(
  parameter int width = WIDTH
) (
  input  logic [2:0]       funct3,
  input  logic [width-1:0] op1,
  input  logic [width-1:0] op2,
  input  logic [width-1:0] result1,
  input  logic [width-1:0] result2,
  output logic             special,
  output logic [width-1:0] special_val,
  output logic [width-1:0] result
);

  logic div_zero;
  logic sgn_ovf;

  assign div_zero = (op2 == '0);
  // Only the signed forms (funct3[0]=0) can overflow: MIN / -1.
  assign sgn_ovf  = ~funct3[0] && (op1 == {1'b1, {(width-1){1'b0}}}) && (op2 == '1);

  // Divide special cases bypass the MCycle unit entirely.
  always_comb begin
    special     = funct3[2] & (div_zero | sgn_ovf);
    special_val = '0;
    if (div_zero)
      special_val = funct3[1] ? op1 : '1;
    else if (sgn_ovf)
      special_val = funct3[1] ? '0 : op1;
  end

  // Pick the result half and turn the unsigned MULHU into MULHSU.
  always_comb begin
    result = result2;
    unique case (funct3)
      FUNCT3_MUL, FUNCT3_DIV, FUNCT3_DIVU: result = result1;
      FUNCT3_MULHSU: result = result2 - (op1[width-1] ? op2 : '0);
      default:       result = result2;
    endcase
  end

endmodule

// File: rtl/mcycle_issue_ctrl.sv
// EX-stage initiator for the MCycle Start/Busy handshake. Issues a one-cycle
// Start, stalls the pipeline until Busy drops, then writes back the fixed-up
// result. Divide-by-zero and signed overflow are resolved locally.
module mcycle_issue_ctrl
  import mcycle_issue_ctrl_pkg::*;
#(
  parameter int width = WIDTH
) (
  input  logic             CLK,
  input  logic             RESETn,
  input  logic             Valid,
  input  logic             Flush,
  input  logic [2:0]       Funct3,
  input  logic [4:0]       Rd,
  input  logic [width-1:0] Operand1,
  input  logic [width-1:0] Operand2,
  output logic             Start,
  output logic [1:0]       MCycleOp,
  output logic [width-1:0] MOperand1,
  output logic [width-1:0] MOperand2,
  input  logic [width-1:0] Result1,
  input  logic [width-1:0] Result2,
  input  logic             Busy,
  output logic             Stall,
  output logic             WE,
  output logic [4:0]       WA,
  output logic [width-1:0] WD
);

  state_t           state;
  logic [2:0]       funct3_q;
  logic [4:0]       rd_q;
  logic [width-1:0] op1_q, op2_q;
  logic             we_q;
  logic [4:0]       wa_q;
  logic [width-1:0] wd_q;

  logic             is_idle;
  logic             accept;
  logic             stall_raw;
  logic [2:0]       fx_funct3;
  logic [width-1:0] fx_op1, fx_op2;
  logic             fx_special;
  logic [width-1:0] fx_special_val;
  logic [width-1:0] fx_result;

  assign is_idle = (state == ST_IDLE);
  assign accept  = is_idle & Valid & ~Flush;

  // In IDLE the live EX operands are inspected; afterwards the latched copy.
  assign fx_funct3 = is_idle ? Funct3   : funct3_q;
  assign fx_op1    = is_idle ? Operand1 : op1_q;
  assign fx_op2    = is_idle ? Operand2 : op2_q;

  m_result_fixup #(.width(width)) u_fixup (
    .funct3      (fx_funct3),
    .op1         (fx_op1),
    .op2         (fx_op2),
    .result1     (Result1),
    .result2     (Result2),
    .special     (fx_special),
    .special_val (fx_special_val),
    .result      (fx_result)
  );

  // Stall is combinational so the issuing instruction freezes in its own cycle.
  always_comb begin
    stall_raw = 1'b0;
    unique case (state)
      ST_IDLE:  stall_raw = accept;
      ST_WAIT:  stall_raw = 1'b1;
      ST_WB:    stall_raw = 1'b0;
      ST_DRAIN: stall_raw = Valid;
      default:  stall_raw = 1'b0;
    endcase
  end

  // Combinational outputs are forced low while reset is asserted.
  assign Start     = RESETn & accept & ~fx_special;
  assign Stall     = RESETn & stall_raw;
  assign MCycleOp  = RESETn ? map_mop(fx_funct3) : 2'b00;
  assign MOperand1 = RESETn ? fx_op1 : '0;
  assign MOperand2 = RESETn ? fx_op2 : '0;
  assign WE        = we_q;
  assign WA        = wa_q;
  assign WD        = wd_q;

  // Issue FSM with operand latches and registered write-back port.
  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      state    <= ST_IDLE;
      funct3_q <= '0;
      rd_q     <= '0;
      op1_q    <= '0;
      op2_q    <= '0;
      we_q     <= 1'b0;
      wa_q     <= '0;
      wd_q     <= '0;
    end else begin
      we_q <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (accept) begin
            funct3_q <= Funct3;
            rd_q     <= Rd;
            op1_q    <= Operand1;
            op2_q    <= Operand2;
            if (fx_special) begin
              wd_q  <= fx_special_val;
              wa_q  <= Rd;
              we_q  <= (Rd != 5'd0);
              state <= ST_WB;
            end else begin
              state <= ST_WAIT;
            end
          end
        end
        ST_WAIT: begin
          // A flush discards the result even if Busy drops on the same edge.
          if (Flush) begin
            state <= ST_DRAIN;
          end else if (!Busy) begin
            wd_q  <= fx_result;
            wa_q  <= rd_q;
            we_q  <= (rd_q != 5'd0);
            state <= ST_WB;
          end
        end
        ST_WB: state <= ST_IDLE;
        ST_DRAIN: if (!Busy) state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mcycle_issue_ctrl.sv
// Randomized bench for mcycle_issue_ctrl with a behavioural MCycle unit of
// configurable latency and a RISC-V M-extension reference model.
module tb_mcycle_issue_ctrl;

  logic        CLK = 1'b0;
  logic        RESETn;
  logic        Valid, Flush;
  logic [2:0]  Funct3;
  logic [4:0]  Rd;
  logic [31:0] Operand1, Operand2;
  logic        Start;
  logic [1:0]  MCycleOp;
  logic [31:0] MOperand1, MOperand2;
  logic [31:0] Result1, Result2;
  logic        Busy;
  logic        Stall, WE;
  logic [4:0]  WA;
  logic [31:0] WD;

  int n_tests = 0;
  int n_fail  = 0;

  mcycle_issue_ctrl #(.width(32)) dut (
    .CLK(CLK), .RESETn(RESETn), .Valid(Valid), .Flush(Flush), .Funct3(Funct3),
    .Rd(Rd), .Operand1(Operand1), .Operand2(Operand2), .Start(Start),
    .MCycleOp(MCycleOp), .MOperand1(MOperand1), .MOperand2(MOperand2),
    .Result1(Result1), .Result2(Result2), .Busy(Busy), .Stall(Stall),
    .WE(WE), .WA(WA), .WD(WD)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- behavioural MCycle unit ----------------
  int          mc_lat = 1;
  int          mc_cnt;
  logic [31:0] pend1, pend2;

  function automatic logic [63:0] mc_compute(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb;
    logic [63:0] ua, ub, r;
    sa = longint'($signed(a)); sb = longint'($signed(b));
    ua = {32'b0, a}; ub = {32'b0, b};
    r = '0;
    case (op)
      2'b00: r = sa * sb;
      2'b01: r = ua * ub;
      2'b10: if (sb != 0) begin
               longint q, m;
               q = sa / sb; m = sa % sb;
               r = {m[31:0], q[31:0]};
             end else r = {a, 32'hFFFFFFFF};
      default: if (ub != 0) begin
               logic [63:0] q, m;
               q = ua / ub; m = ua % ub;
               r = {m[31:0], q[31:0]};
             end else r = {a, 32'hFFFFFFFF};
    endcase
    return r;
  endfunction

  // Results stay garbage until the final compute cycle.
  always @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      mc_cnt <= 0; Result1 <= '0; Result2 <= '0;
    end else if (Start) begin
      logic [63:0] r;
      r = mc_compute(MCycleOp, MOperand1, MOperand2);
      if (mc_lat <= 1) begin
        mc_cnt <= 0; Result1 <= r[31:0]; Result2 <= r[63:32];
      end else begin
        mc_cnt <= mc_lat - 1; pend1 <= r[31:0]; pend2 <= r[63:32];
        Result1 <= 32'hDEADBEEF; Result2 <= 32'hBADC0DE5;
      end
    end else if (mc_cnt != 0) begin
      mc_cnt <= mc_cnt - 1;
      if (mc_cnt == 1) begin Result1 <= pend1; Result2 <= pend2; end
    end
  end

  assign Busy = Start | (mc_cnt != 0);

  // ---------------- reference model ----------------
  function automatic logic [31:0] ref_wd(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb;
    logic [63:0] ua, ub, p;
    bit ovf;
    sa = longint'($signed(a)); sb = longint'($signed(b));
    ua = {32'b0, a}; ub = {32'b0, b};
    ovf = (a == 32'h80000000) && (b == 32'hFFFFFFFF);
    p = '0;
    case (f3)
      3'd0: begin p = ua * ub; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * longint'(ub); return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFFFFFF;
        if (ovf) return 32'h80000000;
        p = sa / sb; return p[31:0];
      end
      3'd5: return (b == 0) ? 32'hFFFFFFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (ovf) return 32'h0;
        p = sa % sb; return p[31:0];
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic logic [1:0] exp_mop(input logic [2:0] f3);
    logic [1:0] t [8] = '{2'b00, 2'b00, 2'b01, 2'b01, 2'b10, 2'b11, 2'b10, 2'b11};
    return t[f3];
  endfunction

  // One instruction held in EX until its write-back cycle.
  task automatic run_op(input logic [2:0] f3, input logic [4:0] rd, input logic [31:0] a,
                        input logic [31:0] b, input int lat);
    logic [31:0] exp;
    bit spec, done, prev_start, op_ok, stall_ok;
    int starts, wb_k;
    exp  = ref_wd(f3, a, b);
    spec = f3[2] && (b == 0 || (!f3[0] && a == 32'h80000000 && b == 32'hFFFFFFFF));
    mc_lat = lat;
    @(negedge CLK);
    Valid = 1'b1; Flush = 1'b0; Funct3 = f3; Rd = rd; Operand1 = a; Operand2 = b;
    starts = 0; wb_k = -1; done = 0; prev_start = 0; op_ok = 1; stall_ok = 1;
    for (int k = 0; k < 80 && !done; k++) begin
      if (k > 0) @(negedge CLK);
      #1;
      if (Start) begin
        starts++;
        if (prev_start || k != 0) op_ok = 0;
        if (MCycleOp != exp_mop(f3) || MOperand1 != a || MOperand2 != b) op_ok = 0;
      end
      prev_start = Start;
      if (!Stall) begin
        done = 1; wb_k = k;
        check("we", WE, rd != 0);
        check("wa_wd", {WA, WD}, {rd, exp});
      end else begin
        if (WE) stall_ok = 0;
        if (MCycleOp != exp_mop(f3)) op_ok = 0;
      end
    end
    check("done", done, 1);
    check("starts", starts, spec ? 0 : 1);
    check("latency", wb_k, spec ? 1 : lat + 1);
    check("mop_hold", op_ok, 1);
    check("stall_we", stall_ok, 1);
    @(negedge CLK);
    Valid = 1'b0;
    #1 check("we_one_cycle", WE, 0);
  endtask

  // Flush after `after` WAIT cycles; no write-back may follow.
  task automatic flush_op(input int lat, input int after);
    int we_cnt, start_cnt;
    mc_lat = lat;
    @(negedge CLK);
    Valid = 1'b1; Funct3 = 3'd4; Rd = 5'd7; Operand1 = 32'd1000; Operand2 = 32'd7;
    #1 check("fl_start", Start, 1);
    repeat (after) @(negedge CLK);
    Flush = 1'b1;
    #1 check("fl_wait_stall", Stall, 1);
    @(negedge CLK);
    Flush = 1'b0; Valid = 1'b0;
    #1 check("fl_drain_nostall", Stall, 0);
    we_cnt = 0; start_cnt = 0;
    if (Busy) begin
      Valid = 1'b1;
      #1 check("fl_drain_stall", Stall, 1);
      Valid = 1'b0;
    end
    for (int k = 0; k < 50; k++) begin
      @(negedge CLK); #1;
      if (WE) we_cnt++;
      if (Start) start_cnt++;
    end
    check("fl_no_we", we_cnt, 0);
    check("fl_no_start", start_cnt, 0);
    check("fl_idle_busy", Busy, 0);
  endtask

  typedef struct { logic [2:0] f3; logic [4:0] rd; logic [31:0] a, b; int lat; } op_t;

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'h80000000;
      2: return 32'hFFFFFFFF;
      3: return $urandom_range(0, 20);
      default: return $urandom;
    endcase
  endfunction

  op_t dir [12];

  initial begin
    dir = '{
      '{3'd0, 5'd1,  32'd7,        32'hFFFFFFFD, 4},
      '{3'd1, 5'd2,  32'h80000000, 32'h80000000, 1},
      '{3'd2, 5'd3,  32'hFFFFFFFF, 32'hFFFFFFFF, 35},
      '{3'd4, 5'd4,  32'hFFFFFFF9, 32'd2,        33},
      '{3'd6, 5'd5,  32'hFFFFFFF9, 32'd2,        2},
      '{3'd7, 5'd6,  32'd100,      32'd7,        17},
      '{3'd5, 5'd7,  32'd5,        32'd0,        10},
      '{3'd6, 5'd8,  32'd5,        32'd0,        10},
      '{3'd4, 5'd9,  32'h80000000, 32'hFFFFFFFF, 10},
      '{3'd6, 5'd10, 32'h80000000, 32'hFFFFFFFF, 10},
      '{3'd0, 5'd0,  32'd3,        32'd5,        3},
      '{3'd3, 5'd31, 32'hFFFFFFFF, 32'hFFFFFFFF, 5}
    };
    RESETn = 1'b0; Valid = 1'b0; Flush = 1'b0; Funct3 = '0; Rd = '0;
    Operand1 = '0; Operand2 = '0;
    #12;
    check("rst_outs", {Start, Stall, WE, WA, WD}, '0);
    @(negedge CLK) RESETn = 1'b1;

    foreach (dir[i]) run_op(dir[i].f3, dir[i].rd, dir[i].a, dir[i].b, dir[i].lat);

    // Valid with Flush in IDLE issues nothing.
    @(negedge CLK);
    Valid = 1'b1; Flush = 1'b1; Funct3 = 3'd0; Rd = 5'd3;
    #1 check("idle_flush", {Start, Stall}, 2'b00);
    @(negedge CLK);
    Valid = 1'b0; Flush = 1'b0;
    #1 check("idle_flush_we", WE, 0);

    flush_op(20, 3);
    run_op(3'd0, 5'd12, 32'd6, 32'd9, 6);
    flush_op(3, 3);          // flush coincides with Busy falling
    run_op(3'd0, 5'd13, 32'hFFFFFFFF, 32'd2, 1);

    // Asynchronous reset in the middle of WAIT.
    mc_lat = 30;
    @(negedge CLK);
    Valid = 1'b1; Funct3 = 3'd0; Rd = 5'd9; Operand1 = 32'd3; Operand2 = 32'd4;
    repeat (5) @(negedge CLK);
    #1 check("mid_wait_stall", Stall, 1);
    #1 RESETn = 1'b0;
    #1 check("async_rst_outs", {Start, Stall, WE, WA, WD}, '0);
    @(negedge CLK);
    Valid = 1'b0;
    @(negedge CLK) RESETn = 1'b1;
    begin
      int we_cnt = 0;
      for (int k = 0; k < 40; k++) begin
        @(negedge CLK); #1;
        if (WE || Start) we_cnt++;
      end
      check("post_rst_quiet", we_cnt, 0);
    end

    for (int n = 0; n < 150; n++)
      run_op(3'($urandom_range(0, 7)), 5'($urandom_range(0, 31)), pick(), pick(),
             $urandom_range(1, 35));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
